// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit. It owns HI/LO, performs single-cycle multiplies,
// and runs an iterative restoring divide that stalls the pipeline until it is done.
module ex_mdu #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              annul_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dvd;   // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   dvs;
  logic [DATA_W-1:0]   rem;
  logic                qneg, rneg;

  logic                is_div, sdiv, acc;
  logic [DATA_W:0]     sh;
  logic [DATA_W+1:0]   diff;
  logic                ge;
  logic [DATA_W-1:0]   nrem, ndvd;
  logic [2*DATA_W-1:0] prod_s, prod_u;

  assign is_div  = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign sdiv    = (op_i == OP_DIV);
  assign stall_o = op_valid_i & ~annul_i & is_div & (state != S_DONE);
  assign busy_o  = (state != S_IDLE);
  assign acc     = op_valid_i & ~annul_i & ~stall_o;

  // One restoring step: shift in next dividend bit, subtract divisor if it fits.
  assign sh   = {rem, dvd[DATA_W-1]};
  assign diff = {1'b0, sh} - {2'b00, dvs};
  assign ge   = ~diff[DATA_W+1];
  assign nrem = ge ? diff[DATA_W-1:0] : sh[DATA_W-1:0];
  assign ndvd = {dvd[DATA_W-2:0], ge};

  assign prod_s = $signed({{DATA_W{rs_i[DATA_W-1]}}, rs_i}) *
                  $signed({{DATA_W{rt_i[DATA_W-1]}}, rt_i});
  assign prod_u = {{DATA_W{1'b0}}, rs_i} * {{DATA_W{1'b0}}, rt_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid_i && !annul_i && is_div) begin
            if (rt_i == '0) begin
              rem   <= rs_i;
              dvd   <= '1;
              state <= S_DONE;
            end else begin
              dvd   <= (sdiv && rs_i[DATA_W-1]) ? -rs_i : rs_i;
              dvs   <= (sdiv && rt_i[DATA_W-1]) ? -rt_i : rt_i;
              qneg  <= sdiv & (rs_i[DATA_W-1] ^ rt_i[DATA_W-1]);
              rneg  <= sdiv & rs_i[DATA_W-1];
              rem   <= '0;
              cnt   <= '0;
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!op_valid_i || annul_i || !is_div) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              dvd   <= qneg ? -ndvd : ndvd;
              rem   <= rneg ? -nrem : nrem;
              state <= S_DONE;
            end else begin
              dvd <= ndvd;
              rem <= nrem;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (acc) begin
        case (op_i)
          OP_MULT:  {hi_o, lo_o} <= prod_s;
          OP_MULTU: {hi_o, lo_o} <= prod_u;
          OP_MTHI:  hi_o <= rs_i;
          OP_MTLO:  lo_o <= rs_i;
          OP_DIV, OP_DIVU: begin
            if (state == S_DONE) begin
              hi_o <= rem;
              lo_o <= dvd;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: stimulus queues expected HI/LO per write op,
// a monitor compares after every accepted write.
module tb_ex_mdu;
  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        annul_i;
  logic        stall_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  ex_mdu #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .annul_i(annul_i),
    .stall_o(stall_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: any accepted HI/LO-writing op must match the head of the scoreboard.
  always @(posedge clk) begin
    logic wr;
    wr = !rst && op_valid_i && !annul_i && !stall_o && (op_i != 3'b000) && (op_i != 3'b111);
    if (wr) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: hi=0x%08h lo=0x%08h with empty scoreboard", hi_o, lo_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi_o, e.hi);
        chk({e.name, "_lo"}, lo_o, e.lo);
      end
    end
  end

  // Issue one op, hold it until accepted, return stall/busy cycle counts.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int exp_stall, input int exp_busy);
    int ns, nb;
    exp_t e;
    e.name = name; e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    @(negedge clk);
    op_valid_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
    #1;
    ns = 0; nb = 0;
    while (stall_o && ns < 100) begin
      ns++;
      if (busy_o) nb++;
      @(negedge clk);
      #1;
    end
    if (busy_o) nb++;
    @(negedge clk);
    op_valid_i = 1'b0; op_i = 3'b000;
    chk({name, "_stall_cycles"}, ns, exp_stall);
    if (exp_busy >= 0) chk({name, "_busy_cycles"}, nb, exp_busy);
  endtask

  // Start DIVU 50/5, then abort it after 10 BUSY cycles by annul or reset.
  task automatic abort_div(input bit use_rst);
    @(negedge clk);
    op_valid_i = 1'b1; op_i = 3'b100; rs_i = 32'd50; rt_i = 32'd5;
    repeat (11) @(negedge clk);
    chk(use_rst ? "rst_mid_busy" : "annul_mid_busy", {31'd0, busy_o}, 32'd1);
    if (use_rst) rst = 1'b1; else annul_i = 1'b1;
    @(negedge clk);
    chk(use_rst ? "rst_busy_low" : "annul_busy_low", {31'd0, busy_o}, 32'd0);
    chk(use_rst ? "rst_hi" : "annul_hi", hi_o, use_rst ? 32'h0 : 32'hA);
    chk(use_rst ? "rst_lo" : "annul_lo", lo_o, use_rst ? 32'h0 : 32'hB);
    rst = 1'b0; annul_i = 1'b0; op_valid_i = 1'b0; op_i = 3'b000;
    repeat (2) @(negedge clk);
    chk(use_rst ? "rst_idle" : "annul_idle", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; op_valid_i = 1'b0; op_i = 3'b000; rs_i = '0; rt_i = '0; annul_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi", hi_o, 32'h0);
    chk("reset_lo", lo_o, 32'h0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);

    do_op("mult",      3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
    do_op("multu",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
    do_op("divu",      3'b100, 32'd100,      32'd7,        32'd2,        32'd14,       33, 33);
    do_op("div_neg",   3'b011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33);
    do_op("div_negd",  3'b011, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, -1);
    do_op("div_wrap",  3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33, -1);
    do_op("divu_big",  3'b100, 32'hFFFFFFFF, 32'd16,       32'hF,        32'h0FFFFFFF, 33, -1);
    do_op("div_zero",  3'b011, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1, 1);
    do_op("mthi",      3'b101, 32'hA,        32'd0,        32'hA,        32'hFFFFFFFF, 0, 0);
    do_op("mtlo",      3'b110, 32'hB,        32'd0,        32'hA,        32'hB,        0, 0);

    abort_div(1'b0);

    // Annulled MULT must leave HI/LO untouched.
    @(negedge clk);
    op_valid_i = 1'b1; op_i = 3'b001; rs_i = 32'd5; rt_i = 32'd5; annul_i = 1'b1;
    @(negedge clk);
    op_valid_i = 1'b0; annul_i = 1'b0; op_i = 3'b000;
    chk("annul_mult_hi", hi_o, 32'hA);
    chk("annul_mult_lo", lo_o, 32'hB);

    abort_div(1'b1);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
